// File: rtl/memory_master_if.sv
// Bundle of every signal between memory_master and its environment, apart from clk and reset.
//   command port : cmd_valid, cmd_ready, cmd_wr, cmd_addr, cmd_wdata
//   result port  : res_valid, res_ready, res_rdata, res_err
//   slave bus    : wr, rd, addr, wdata, rdata, response
//   status       : err_count
// The master modport is the memory_master view. The slave modport is the view of the
// environment that issues commands and plays the memory slave.
interface memory_master_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_rdata;
    logic [1:0]            res_err;
    logic                  wr;
    logic                  rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  response;
    logic [7:0]            err_count;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, res_ready, rdata, response,
        output cmd_ready, res_valid, res_rdata, res_err, wr, rd, addr, wdata, err_count
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, res_ready, rdata, response,
        input  cmd_ready, res_valid, res_rdata, res_err, wr, rd, addr, wdata, err_count
    );
endinterface

// File: rtl/memory_master.sv
// memory_master: bus initiator for the memory slave. It accepts one read or write command,
// drives a single bus transaction for it, then presents read data and a status code on the
// result port.
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-low
//   bus   : memory_master_if.master
//           command port (valid/ready), result port (valid/ready), slave bus strobes,
//           and err_count
// Status codes: 00 ok, 01 address out of range, 10 slave timeout.
module memory_master #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 16,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    memory_master_if.master   bus
);
    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    localparam int unsigned            CntWidth = $clog2(TIMEOUT);
    localparam logic [CntWidth-1:0]    CntLast  = CntWidth'(TIMEOUT - 1);
    localparam logic [1:0]             ErrOk    = 2'b00;
    localparam logic [1:0]             ErrRange = 2'b01;
    localparam logic [1:0]             ErrTmo   = 2'b10;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] res_rdata_q, res_rdata_d;
    logic [1:0]            res_err_q, res_err_d;
    logic [7:0]            err_count_q, err_count_d;
    logic                  err_entry;

    // Ready is gated by reset so no command is taken while reset is being asserted.
    assign bus.cmd_ready = (state_q == StIdle) && reset;
    assign bus.res_valid = (state_q == StDone);
    assign bus.wr        = wr_q;
    assign bus.rd        = rd_q;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.res_rdata = res_rdata_q;
    assign bus.res_err   = res_err_q;
    assign bus.err_count = err_count_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        res_rdata_d = res_rdata_q;
        res_err_d   = res_err_q;
        err_entry   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    if (32'(bus.cmd_addr) >= MEM_SIZE) begin
                        // Rejected without touching the bus.
                        state_d     = StDone;
                        res_rdata_d = '0;
                        res_err_d   = ErrRange;
                        err_entry   = 1'b1;
                    end else begin
                        state_d = StReq;
                        cnt_d   = '0;
                        addr_d  = bus.cmd_addr;
                        wdata_d = bus.cmd_wr ? bus.cmd_wdata : '0;
                        wr_d    = bus.cmd_wr;
                        rd_d    = !bus.cmd_wr;
                    end
                end
            end
            StReq: begin
                // A response on the last allowed cycle still counts as success.
                if (bus.response) begin
                    state_d     = StDone;
                    wr_d        = 1'b0;
                    rd_d        = 1'b0;
                    res_rdata_d = rd_q ? bus.rdata : '0;
                    res_err_d   = ErrOk;
                end else if (cnt_q == CntLast) begin
                    state_d     = StDone;
                    wr_d        = 1'b0;
                    rd_d        = 1'b0;
                    res_rdata_d = '0;
                    res_err_d   = ErrTmo;
                    err_entry   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        err_count_d = err_count_q;
        if (err_entry && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            res_rdata_q <= '0;
            res_err_q   <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            res_rdata_q <= res_rdata_d;
            res_err_q   <= res_err_d;
            err_count_q <= err_count_d;
        end
    end
endmodule
